// File: rtl/data_sram_slave_if.sv
// Data-SRAM request/response bundle between the CPU core and its memory-side responder.
//   data_sram_en    : request valid this cycle
//   data_sram_wen   : byte write enables (0 = read)
//   data_sram_addr  : physical byte address
//   data_sram_wdata : lane-aligned store data
//   data_sram_rdata : registered read data, one-cycle latency
interface data_sram_slave_if;
  logic        data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_en,
    output data_sram_wen,
    output data_sram_addr,
    output data_sram_wdata,
    input  data_sram_rdata
  );

  modport slave (
    input  data_sram_en,
    input  data_sram_wen,
    input  data_sram_addr,
    input  data_sram_wdata,
    output data_sram_rdata
  );
endinterface

// File: rtl/data_sram_slave.sv
// Responder end of the CPU data-SRAM port. Serves a word-organised data RAM and a small
// config-register window (LED, numeric display, switches, free-running timer). Reads return
// on a fixed one-cycle latency, read-first on stores; no stall, no back-pressure.
//   i_clk        : core clock, all state updates on posedge
//   i_resetn     : synchronous active-low reset
//   sram         : data-SRAM request/response bundle (slave side)
//   i_switch_in  : asynchronous board switches
//   o_led_out    : LED register
//   o_num_out    : numeric-display register
//   o_timer_out  : current timer value
module data_sram_slave #(
  parameter int unsigned MEM_AW    = 12,
  parameter logic [15:0] CONF_HI   = 16'h1faf,
  parameter logic [15:0] LED_RESET = 16'hffff
) (
  input  logic                    i_clk,
  input  logic                    i_resetn,
  data_sram_slave_if.slave        sram,
  input  logic [7:0]              i_switch_in,
  output logic [15:0]             o_led_out,
  output logic [31:0]             o_num_out,
  output logic [31:0]             o_timer_out
);

  localparam int unsigned MemWords = 1 << MEM_AW;

  localparam logic [15:0] OffLed   = 16'hf000;
  localparam logic [15:0] OffNum   = 16'hf010;
  localparam logic [15:0] OffSw    = 16'hf020;
  localparam logic [15:0] OffTimer = 16'he000;

  logic [31:0] r_mem [MemWords];

  logic [31:0] r_rdata;
  logic [15:0] r_led;
  logic [31:0] r_num;
  logic [31:0] r_timer;
  logic [7:0]  r_sw_meta;
  logic [7:0]  r_sw_sync;

  logic              w_wr;
  logic              w_conf_sel;
  logic [15:0]       w_off;
  logic [MEM_AW-1:0] w_idx;
  logic              w_hit_led;
  logic              w_hit_num;
  logic              w_hit_sw;
  logic              w_hit_timer;
  logic [31:0]       w_wmask;
  logic [31:0]       w_rd_word;
  logic [15:0]       w_led_d;
  logic [31:0]       w_num_d;
  logic [31:0]       w_timer_inc;
  logic [31:0]       w_timer_d;
  logic              w_unused;

  // Byte offset bits never select anything; the window decode is word-granular.
  assign w_unused   = ^sram.data_sram_addr[1:0];

  assign w_wr       = sram.data_sram_en & (|sram.data_sram_wen);
  assign w_conf_sel = (sram.data_sram_addr[31:16] == CONF_HI);
  assign w_off      = {sram.data_sram_addr[15:2], 2'b00};
  assign w_idx      = sram.data_sram_addr[MEM_AW+1:2];

  assign w_hit_led   = w_conf_sel & (w_off == OffLed);
  assign w_hit_num   = w_conf_sel & (w_off == OffNum);
  assign w_hit_sw    = w_conf_sel & (w_off == OffSw);
  assign w_hit_timer = w_conf_sel & (w_off == OffTimer);

  assign w_wmask = {{8{sram.data_sram_wen[3]}}, {8{sram.data_sram_wen[2]}},
                    {8{sram.data_sram_wen[1]}}, {8{sram.data_sram_wen[0]}}};

  // Read mux sees pre-edge state, which gives read-first behaviour on stores and the
  // pre-increment timer value.
  always_comb begin
    w_rd_word = '0;
    if (w_conf_sel) begin
      if (w_hit_led) begin
        w_rd_word = {16'h0000, r_led};
      end else if (w_hit_num) begin
        w_rd_word = r_num;
      end else if (w_hit_sw) begin
        w_rd_word = {24'h000000, r_sw_sync};
      end else if (w_hit_timer) begin
        w_rd_word = r_timer;
      end
    end else begin
      w_rd_word = r_mem[w_idx];
    end
  end

  always_comb begin
    w_led_d = r_led;
    if (w_wr && w_hit_led) begin
      w_led_d = (r_led & ~w_wmask[15:0]) | (sram.data_sram_wdata[15:0] & w_wmask[15:0]);
    end
  end

  always_comb begin
    w_num_d = r_num;
    if (w_wr && w_hit_num) begin
      w_num_d = (r_num & ~w_wmask) | (sram.data_sram_wdata & w_wmask);
    end
  end

  // Written lanes load store data; unwritten lanes still advance with the increment.
  assign w_timer_inc = r_timer + 32'd1;

  always_comb begin
    w_timer_d = w_timer_inc;
    if (w_wr && w_hit_timer) begin
      w_timer_d = (w_timer_inc & ~w_wmask) | (sram.data_sram_wdata & w_wmask);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rdata   <= '0;
      r_led     <= LED_RESET;
      r_num     <= '0;
      r_timer   <= '0;
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      if (sram.data_sram_en) begin
        r_rdata <= w_rd_word;
      end
      r_led     <= w_led_d;
      r_num     <= w_num_d;
      r_timer   <= w_timer_d;
      r_sw_meta <= i_switch_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // RAM has no reset; a store coinciding with reset is dropped.
  always_ff @(posedge i_clk) begin
    if (i_resetn && w_wr && !w_conf_sel) begin
      for (int i = 0; i < 4; i++) begin
        if (sram.data_sram_wen[i]) begin
          r_mem[w_idx][8*i +: 8] <= sram.data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  assign sram.data_sram_rdata = r_rdata;
  assign o_led_out            = r_led;
  assign o_num_out            = r_num;
  assign o_timer_out          = r_timer;

endmodule

// File: tb/tb_data_sram_slave.sv
module tb_data_sram_slave;

  localparam int unsigned MemAw = 12;

  logic        clk;
  logic        resetn;
  logic [7:0]  sw;
  logic [15:0] led_out;
  logic [31:0] num_out;
  logic [31:0] timer_out;

  data_sram_slave_if sram ();

  data_sram_slave #(
    .MEM_AW   (MemAw),
    .CONF_HI  (16'h1faf),
    .LED_RESET(16'hffff)
  ) dut (
    .i_clk      (clk),
    .i_resetn   (resetn),
    .sram       (sram),
    .i_switch_in(sw),
    .o_led_out  (led_out),
    .o_num_out  (num_out),
    .o_timer_out(timer_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_mem [int];
  logic [31:0] m_rdata;
  bit          m_rd_known = 0;
  bit          m_valid = 0;
  logic [15:0] m_led;
  logic [31:0] m_num;
  logic [31:0] m_timer;
  logic [7:0]  m_sw_meta;
  logic [7:0]  m_sw_sync;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] wen);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (wen[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] conf_read(input logic [15:0] off);
    case (off)
      16'hf000: return {16'h0, m_led};
      16'hf010: return m_num;
      16'hf020: return {24'h0, m_sw_sync};
      16'he000: return m_timer;
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input bit rstn, input bit en, input logic [3:0] wen,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [7:0] swv);
    logic [31:0] nxt_timer;
    logic [31:0] tmp;
    logic [15:0] off;
    int          idx;
    bit          conf;
    if (!rstn) begin
      m_rdata    = 32'h0;
      m_rd_known = 1;
      m_led      = 16'hffff;
      m_num      = 32'h0;
      m_timer    = 32'h0;
      m_sw_meta  = 8'h0;
      m_sw_sync  = 8'h0;
      m_valid    = 1;
      return;
    end
    nxt_timer = m_timer + 32'd1;
    if (en) begin
      conf = (addr[31:16] == 16'h1faf);
      off  = {addr[15:2], 2'b00};
      idx  = int'((addr >> 2) & ((32'd1 << MemAw) - 1));
      if (conf) begin
        m_rdata    = conf_read(off);
        m_rd_known = 1;
      end else if (m_mem.exists(idx)) begin
        m_rdata    = m_mem[idx];
        m_rd_known = 1;
      end else begin
        m_rd_known = 0;
      end
      if (wen != 4'h0) begin
        if (conf) begin
          case (off)
            16'hf000: begin tmp = merge({16'h0, m_led}, wdata, wen); m_led = tmp[15:0]; end
            16'hf010: m_num = merge(m_num, wdata, wen);
            16'he000: nxt_timer = merge(nxt_timer, wdata, wen);
            default: ;
          endcase
        end else begin
          tmp = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
          m_mem[idx] = merge(tmp, wdata, wen);
        end
      end
    end
    m_sw_sync = m_sw_meta;
    m_sw_meta = swv;
    m_timer   = nxt_timer;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      if (m_rd_known) chk("rdata", sram.data_sram_rdata, m_rdata);
      chk("led_out", {16'h0, led_out}, {16'h0, m_led});
      chk("num_out", num_out, m_num);
      chk("timer_out", timer_out, m_timer);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit rstn, input bit en, input logic [3:0] wen,
                     input logic [31:0] addr, input logic [31:0] wdata);
    resetn               = rstn;
    sram.data_sram_en    = en;
    sram.data_sram_wen   = wen;
    sram.data_sram_addr  = addr;
    sram.data_sram_wdata = wdata;
    @(posedge clk);
    #1;
    model_edge(rstn, en, wen, addr, wdata, sw);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] wen);
    cyc(1'b1, 1'b1, wen, addr, data);
  endtask

  task automatic rd(input logic [31:0] addr);
    cyc(1'b1, 1'b1, 4'h0, addr, 32'h0);
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    sw = 8'h00;
    // Establish known RAM word, then reset with a colliding store that must be dropped.
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    wr(32'h0000_0200, 32'h0101_0101, 4'hf);
    cyc(1'b0, 1'b1, 4'hf, 32'h0000_0200, 32'hbad0_bad0);
    cyc(1'b0, 1'b1, 4'hf, 32'h0000_0200, 32'hbad0_bad0);
    chk("rst_rdata", sram.data_sram_rdata, 32'h0);
    chk("rst_led", {16'h0, led_out}, 32'h0000_ffff);
    chk("rst_num", num_out, 32'h0);
    chk("rst_timer", timer_out, 32'h0);
    idle();
    chk("timer_1", timer_out, 32'd1);
    idle();
    chk("timer_2", timer_out, 32'd2);
    rd(32'h0000_0200);
    chk("rst_drop", sram.data_sram_rdata, 32'h0101_0101);

    // Byte-lane store then load.
    wr(32'h0000_0100, 32'h1122_3344, 4'hf);
    wr(32'h0000_0100, 32'h0000_aa00, 4'b0010);
    chk("store_rdfirst", sram.data_sram_rdata, 32'h1122_3344);
    rd(32'h0000_0100);
    chk("lane_load", sram.data_sram_rdata, 32'h1122_aa44);

    // Alias across the top of RAM.
    wr(32'h0000_0000, 32'hdead_beef, 4'hf);
    rd(32'h0000_4000);
    chk("alias", sram.data_sram_rdata, 32'hdead_beef);

    // Config registers.
    wr(32'h1faf_f000, 32'h0000_a5a5, 4'hf);
    chk("led_wr", {16'h0, led_out}, 32'h0000_a5a5);
    wr(32'h1faf_f010, 32'h1234_5678, 4'hf);
    chk("num_wr", num_out, 32'h1234_5678);
    rd(32'h1faf_f000);
    chk("led_rd", sram.data_sram_rdata, 32'h0000_a5a5);
    rd(32'h1faf_f010);
    chk("num_rd", sram.data_sram_rdata, 32'h1234_5678);
    rd(32'h1faf_f100);
    chk("unmapped_rd", sram.data_sram_rdata, 32'h0);
    wr(32'h1faf_f020, 32'hffff_ffff, 4'hf);
    rd(32'h1faf_f020);
    chk("sw_ro", sram.data_sram_rdata, 32'h0);
    wr(32'h1faf_f000, 32'h0000_ff00, 4'b0010);
    chk("led_lane", {16'h0, led_out}, 32'h0000_ffa5);

    // Timer load beats increment, then wraps.
    wr(32'h1faf_e000, 32'hffff_fffe, 4'hf);
    chk("tmr_load", timer_out, 32'hffff_fffe);
    rd(32'h1faf_e000);
    chk("tmr_rd0", sram.data_sram_rdata, 32'hffff_fffe);
    chk("tmr_out1", timer_out, 32'hffff_ffff);
    rd(32'h1faf_e000);
    chk("tmr_rd1", sram.data_sram_rdata, 32'hffff_ffff);
    chk("tmr_wrap", timer_out, 32'h0);
    // Partial load: low lane written, upper lanes take the increment.
    wr(32'h1faf_e000, 32'h0000_00aa, 4'b0001);
    chk("tmr_lane", timer_out, 32'h0000_00aa);

    // Switch synchronizer and idle hold.
    sw = 8'h5a;
    idle();
    rd(32'h1faf_f020);
    chk("sw_early", sram.data_sram_rdata, 32'h0);
    idle();
    chk("hold_1", sram.data_sram_rdata, 32'h0);
    idle();
    chk("hold_2", sram.data_sram_rdata, 32'h0);
    rd(32'h1faf_f020);
    chk("sw_late", sram.data_sram_rdata, 32'h0000_005a);
    idle();
    chk("hold_3", sram.data_sram_rdata, 32'h0000_005a);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
